// File: rtl/primogen_pkg.sv
// Shared definitions for the primogen_param prime generator.
//   state_t      : search FSM states
//   RES_RESET    : value of res after reset
//   D0_*, STEP_* : first trial divisor and divisor step for each build
//   wheel_step   : candidate step from (c mod 6) to the next 6k+-1 value
//   mod6_shift / mod6_add : incremental residue-mod-6 helpers
// Build option: PRIMOGEN_WHEEL_EN selects the 6k+-1 wheel.
package primogen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NEXT,
        DIV_START,
        DIV_WAIT,
        CHECK
    } state_t;

    localparam int unsigned RES_RESET  = 1;
    localparam int unsigned D0_PLAIN   = 3;
    localparam int unsigned D0_WHEEL   = 5;
    localparam int unsigned STEP_SHORT = 2;
    localparam int unsigned STEP_LONG  = 4;

    // Step that moves a value with residue m (mod 6) to the next residue 1 or 5.
    function automatic logic [2:0] wheel_step(input logic [2:0] m);
        logic [2:0] st;
        case (m)
            3'd0:    st = 3'd1;
            3'd1:    st = 3'd4;
            3'd2:    st = 3'd3;
            3'd3:    st = 3'd2;
            3'd4:    st = 3'd1;
            default: st = 3'd2;
        endcase
        return st;
    endfunction

    // (2*r + b) mod 6, used to fold a number into its residue MSB first.
    function automatic logic [2:0] mod6_shift(input logic [2:0] r, input logic b);
        logic [3:0] t;
        t = {r, b};
        if (t >= 4'd6) t = t - 4'd6;
        return t[2:0];
    endfunction

    // (m + st) mod 6 for m < 6 and st <= 5.
    function automatic logic [2:0] mod6_add(input logic [2:0] m, input logic [2:0] st);
        logic [3:0] t;
        t = {1'b0, m} + {1'b0, st};
        if (t >= 4'd6) t = t - 4'd6;
        return t[2:0];
    endfunction

endpackage

// File: rtl/primogen_rem.sv
// Restoring remainder unit: rem = num mod den, one quotient bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : launch (ignored while busy)
//   num, den : dividend / divisor (den must be non-zero)
//   done     : one-cycle pulse when rem is valid
//   rem      : remainder, held until the next launch
module primogen_rem #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             done,
    output logic [WIDTH-1:0] rem
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dv;
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;

    // The partial remainder stays below den, so the shifted value needs one
    // extra bit; the top bit of the difference is the borrow.
    always_comb begin
        r_sh = {r, q[WIDTH-1]};
        diff = r_sh - {1'b0, dv};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            q    <= '0;
            dv   <= '0;
            r    <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                r   <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                q   <= q << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                busy <= 1'b1;
                q    <= num;
                dv   <= den;
                r    <= '0;
                cnt  <= CW'(WIDTH);
            end
        end
    end

    assign rem = r;

endmodule

// File: rtl/primogen_param.sv
// Sequential prime generator: each accepted go returns the smallest prime
// strictly greater than res, found by odd trial division.
//   clk, rst : clock, synchronous active-high reset (aborts any search)
//   go       : request next prime (taken when ready and no ld and no error)
//   ld, seed : load seed into res and clear error (taken when ready)
//   ready    : idle, res valid
//   error    : sticky, no larger prime fits in WIDTH bits
//   res      : current prime or loaded seed
// Build option: PRIMOGEN_WHEEL_EN restricts candidates and divisors to 6k+-1.
module primogen_param
    import primogen_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             ld,
    input  logic [WIDTH-1:0] seed,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] res
);
    localparam int unsigned SQW = 2 * WIDTH;
`ifdef PRIMOGEN_WHEEL_EN
    localparam int unsigned D0 = D0_WHEEL;
`else
    localparam int unsigned D0 = D0_PLAIN;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] res_n, cand, cand_n, d, d_n;
    logic [SQW-1:0]   sq, sq_n, d_ext;
    logic [2:0]       s, s_n;     // current divisor step (2 or 4)
    logic [2:0]       rm, rm_n;   // res mod 6
    logic [2:0]       cm, cm_n;   // cand mod 6
    logic [2:0]       seed_m6, step;
    logic [WIDTH:0]   sum;
    logic             error_n;
    logic             rem_start, rem_done;
    logic [WIDTH-1:0] rem_val;

    primogen_rem #(.WIDTH(WIDTH)) u_rem (
        .clk   (clk),
        .rst   (rst),
        .start (rem_start),
        .num   (cand),
        .den   (d),
        .done  (rem_done),
        .rem   (rem_val)
    );

    // The residue of res mod 6 is tracked so the wheel can align a freshly
    // loaded seed without a divider; only ld needs a full fold.
    always_comb begin
        seed_m6 = '0;
        for (int unsigned i = 0; i < WIDTH; i++)
            seed_m6 = mod6_shift(seed_m6, seed[WIDTH-1-i]);
    end

    always_comb begin
        state_n   = state;
        res_n     = res;
        error_n   = error;
        cand_n    = cand;
        cm_n      = cm;
        rm_n      = rm;
        d_n       = d;
        sq_n      = sq;
        s_n       = s;
        rem_start = 1'b0;
        d_ext     = {{WIDTH{1'b0}}, d};
`ifdef PRIMOGEN_WHEEL_EN
        step      = wheel_step(cm);
`else
        step      = cand[0] ? 3'(STEP_SHORT) : 3'd1;
`endif
        sum       = {1'b0, cand} + {{(WIDTH-2){1'b0}}, step};

        case (state)
            IDLE: begin
                if (ld) begin
                    res_n   = seed;
                    error_n = 1'b0;
                    rm_n    = seed_m6;
                end else if (go && !error) begin
                    cand_n  = res;
                    cm_n    = rm;
                    state_n = NEXT;
                end
            end
            NEXT: begin
                if (res < WIDTH'(2)) begin
                    res_n   = WIDTH'(2);
                    rm_n    = 3'd2;
                    state_n = IDLE;
                end else if (res == WIDTH'(2)) begin
                    res_n   = WIDTH'(3);
                    rm_n    = 3'd3;
                    state_n = IDLE;
                end else if (sum[WIDTH]) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    cand_n  = sum[WIDTH-1:0];
                    cm_n    = mod6_add(cm, step);
                    d_n     = WIDTH'(D0);
                    sq_n    = SQW'(D0 * D0);
                    s_n     = 3'(STEP_SHORT);
                    state_n = DIV_START;
                end
            end
            DIV_START: begin
                if (sq > {{WIDTH{1'b0}}, cand}) begin
                    res_n   = cand;
                    rm_n    = cm;
                    state_n = IDLE;
                end else begin
                    rem_start = 1'b1;
                    state_n   = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (rem_done) state_n = CHECK;
            end
            CHECK: begin
                if (rem_val == '0) begin
                    state_n = NEXT;
                end else begin
                    // (d+s)^2 = d^2 + 2*s*d + s^2 with s in {2,4}
                    d_n = d + WIDTH'(s);
                    if (s == 3'(STEP_LONG))
                        sq_n = sq + (d_ext << 3) + SQW'(16);
                    else
                        sq_n = sq + (d_ext << 2) + SQW'(4);
`ifdef PRIMOGEN_WHEEL_EN
                    s_n = (s == 3'(STEP_LONG)) ? 3'(STEP_SHORT) : 3'(STEP_LONG);
`endif
                    state_n = DIV_START;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            res   <= WIDTH'(RES_RESET);
            error <= 1'b0;
            cand  <= '0;
            cm    <= '0;
            rm    <= 3'(RES_RESET);
            d     <= '0;
            sq    <= '0;
            s     <= 3'(STEP_SHORT);
        end else begin
            state <= state_n;
            res   <= res_n;
            error <= error_n;
            cand  <= cand_n;
            cm    <= cm_n;
            rm    <= rm_n;
            d     <= d_n;
            sq    <= sq_n;
            s     <= s_n;
        end
    end

    assign ready = (state == IDLE);

endmodule

// File: tb/tb_primogen_param.sv
// Self-checking bench for primogen_param: one 8-bit and one 16-bit instance.
// Build option PRIMOGEN_WHEEL_EN also enables the wheel latency check.
module tb_primogen_param;

    localparam int unsigned LIMIT = 5000;
    // Total request latency of the 12-prime run in the plain (non-wheel) build.
    localparam int unsigned PLAIN_CYCLES = 421;

    logic        clk = 1'b0;
    logic        rst;
    logic        go8, ld8, ready8, error8;
    logic [7:0]  seed8, res8;
    logic        go16, ld16, ready16, error16;
    logic [15:0] seed16, res16;

    always #5 clk = ~clk;

    primogen_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .go(go8), .ld(ld8), .seed(seed8),
        .ready(ready8), .error(error8), .res(res8)
    );

    primogen_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .go(go16), .ld(ld16), .seed(seed16),
        .ready(ready16), .error(error16), .res(res16)
    );

    typedef struct {
        int unsigned res;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic rdy(input bit w8);
        return w8 ? ready8 : ready16;
    endfunction

    function automatic logic errv(input bit w8);
        return w8 ? error8 : error16;
    endfunction

    function automatic logic [31:0] resv(input bit w8);
        return w8 ? {24'd0, res8} : {16'd0, res16};
    endfunction

    task automatic load(input bit w8, input int unsigned v);
        @(negedge clk);
        if (w8) begin ld8 = 1'b1; seed8 = v[7:0]; end
        else    begin ld16 = 1'b1; seed16 = v[15:0]; end
        @(negedge clk);
        ld8  = 1'b0;
        ld16 = 1'b0;
    endtask

    // Pulse go, wait (bounded) for ready, then compare against the scoreboard.
    task automatic request(input bit w8, input int unsigned exp_res, input bit exp_err,
                           input string tag, output int unsigned lat);
        exp_t e;
        e.res = exp_res;
        e.err = exp_err;
        sb.push_back(e);
        @(negedge clk);
        if (w8) go8 = 1'b1; else go16 = 1'b1;
        @(negedge clk);
        go8  = 1'b0;
        go16 = 1'b0;
        lat  = 1;
        while (!rdy(w8) && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        if (!rdy(w8)) check_val({tag, "_timeout"}, 32'(rdy(w8)), 32'd1);
        e = sb.pop_front();
        check_val({tag, "_res"}, resv(w8), e.res);
        check_val({tag, "_err"}, 32'(errv(w8)), 32'(e.err));
    endtask

    int unsigned primes[12] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37};

    initial begin
        int unsigned lat, total;
        exp_t e;
        go8 = 0; ld8 = 0; seed8 = '0;
        go16 = 0; ld16 = 0; seed16 = '0;
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        rst = 1'b0;
        check_val("rst16_res", resv(0), 1);
        check_val("rst16_rdy", 32'(ready16), 1);
        check_val("rst16_err", 32'(error16), 0);
        check_val("rst8_res", resv(1), 1);
        check_val("rst8_rdy", 32'(ready8), 1);

        // Successive primes from reset
        total = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            request(0, primes[i], 0, $sformatf("seq%0d", i), lat);
            if (i < 2) check_val($sformatf("seq%0d_lat", i), lat, 2);
            total += lat;
        end
`ifdef PRIMOGEN_WHEEL_EN
        check_val("wheel_faster", 32'(total < PLAIN_CYCLES), 1);
`endif

        // 8-bit overflow and error handling
        load(1, 250);
        request(1, 251, 0, "w8_251", lat);
        request(1, 251, 1, "w8_ovf", lat);
        check_val("w8_ovf_rdy", 32'(ready8), 1);
        request(1, 251, 1, "w8_ignored", lat);
        check_val("w8_ignored_lat", lat, 1);
        load(1, 0);
        check_val("w8_clr_err", 32'(error8), 0);
        check_val("w8_clr_res", resv(1), 0);
        request(1, 2, 0, "w8_from0", lat);

        // 16-bit seeds
        load(0, 65520);
        request(0, 65521, 0, "w16_65521", lat);
        load(0, 1000);
        request(0, 1009, 0, "w16_1009", lat);
        load(0, 1009);
        request(0, 1013, 0, "w16_1013", lat);

        // Extra go pulses during a search are dropped
        load(0, 31);
        e.res = 37;
        e.err = 0;
        sb.push_back(e);
        @(negedge clk);
        go16 = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clk);
            go16 = k[0];
        end
        go16 = 1'b0;
        lat = 0;
        while (!ready16 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check_val("busy_go_res", resv(0), e.res);
        repeat (5) @(negedge clk);
        check_val("busy_go_idle", 32'(ready16), 1);
        check_val("busy_go_hold", resv(0), e.res);

        // ld and go together: only the load happens
        @(negedge clk);
        ld16 = 1'b1; go16 = 1'b1; seed16 = 16'd100;
        @(negedge clk);
        ld16 = 1'b0; go16 = 1'b0;
        check_val("ldgo_res", resv(0), 100);
        check_val("ldgo_rdy", 32'(ready16), 1);
        repeat (3) @(negedge clk);
        check_val("ldgo_hold", resv(0), 100);
        check_val("ldgo_rdy2", 32'(ready16), 1);

        // Reset in the middle of a search
        load(0, 23);
        @(negedge clk);
        go16 = 1'b1;
        @(negedge clk);
        go16 = 1'b0;
        repeat (4) @(negedge clk);
        check_val("mid_busy", 32'(ready16), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_res", resv(0), 1);
        check_val("mid_rst_rdy", 32'(ready16), 1);
        check_val("mid_rst_err", 32'(error16), 0);
        request(0, 2, 0, "after_rst", lat);
        check_val("after_rst_lat", lat, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
